async_fifo_wr_arbiter: RTL
==========================

# async_fifo_wr_arbiter

Round-robin, burst-locked write arbiter that shares the write port of one `async_fifo` (write-clock side) among `NUM_REQ` producers. Each accepted beat is tagged with its source index, so the read side can demultiplex. It drives `data_in` / `wrt_en` of the FIFO directly, and honours `wrt_full` so that no write is issued into a full FIFO. It runs entirely in the FIFO write-clock domain.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_LEN`, default 16: payload width per beat.
- `ID_LEN`, default `$clog2(NUM_REQ)`: source-tag width.
- `MAX_BURST`, default 4: maximum beats per grant, ≥1.
- `clk`  in  1: the FIFO write clock (`wclk`).
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  `NUM_REQ`: per-requester beat valid.
- `req_last`  in  `NUM_REQ`: marks the final beat of a packet; sampled with valid.
- `req_data`  in  `NUM_REQ*DATA_LEN`: requester i occupies bits `[i*DATA_LEN +: DATA_LEN]`.
- `req_ready`  out  `NUM_REQ`: beat accepted this cycle (one-hot or zero).
- `fifo_data_in`  out  `ID_LEN+DATA_LEN`: `{grant_id, req_data[grant_id]}`; goes to FIFO `data_in`.
- `fifo_wrt_en`  out  1: goes to FIFO `wrt_en`.
- `fifo_wrt_full`  in  1: from FIFO `wrt_full`.
- `busy`  out  1: a grant is held.
- `grant_id`  out  `ID_LEN`: current or last granted requester.
- `beat_count`  out  32: total beats written since reset; wraps modulo 2^32.

## Operation
- States: IDLE and BUSY. Registers: `state`, `grant_id`, `rr_ptr` (`ID_LEN`), `burst_cnt` (`$clog2(MAX_BURST)+1`), `beat_count`.
- IDLE: if any `req_valid`, select the first valid index at or after `rr_ptr`, scanning cyclically upward with wrap. Load `grant_id`, clear `burst_cnt`, and go to BUSY. Otherwise stay in IDLE. No beat is accepted in IDLE.
- BUSY, beat transfer: `xfer = req_valid[grant_id] & ~fifo_wrt_full`. The transfer drives `fifo_wrt_en = xfer` and `req_ready[grant_id] = xfer`. All other ready bits are 0. It also increments `burst_cnt` and `beat_count`.
- BUSY, release: release when `xfer & (req_last[grant_id] | burst_cnt == MAX_BURST-1)`, or when `req_valid[grant_id] == 0`, whether or not the FIFO is full.
  - On release, set `rr_ptr <= (grant_id+1) mod NUM_REQ` and `state <= IDLE`.
  - The last beat is written in the release cycle.
- BUSY while `fifo_wrt_full` is 1 with the requester still valid: the grant is held. `burst_cnt` is frozen, `fifo_wrt_en` is 0, and `req_ready` is 0.
- `fifo_data_in` always reflects `{grant_id, req_data[grant_id]}`. It is meaningful only when `fifo_wrt_en` is 1.
- `fifo_wrt_en` and `req_ready` are combinational from registered state and live inputs. Both are forced to 0 while `reset` is 1.
- Reset values: `state` IDLE, `rr_ptr` 0, `grant_id` 0, `burst_cnt` 0, `beat_count` 0, `busy` 0, `req_ready` 0, `fifo_wrt_en` 0.
- Reset mid-burst: the burst is abandoned and no beat is written in the reset cycle. The FIFO's own `reset` is driven separately and is not touched by this block.
- `MAX_BURST == 1`: every transfer releases.

## Timing
- Arbitration latency: a valid raised in cycle N while in IDLE gives `busy = 1` and a possible first write in cycle N+1.
- Minimum inter-grant gap: one IDLE cycle after each release.
- Peak throughput: `MAX_BURST/(MAX_BURST+1)` beats per clock.
- Handshake: a beat is consumed exactly on the cycle where `req_ready[i]` is 1. The requester must hold `req_data` and `req_last` stable while `req_valid` is 1 and `req_ready` is 0.
- `fifo_wrt_full` is sampled combinationally in the same cycle. A write and `fifo_wrt_full == 1` are never concurrent.
- Fairness bound: a continuously valid requester is granted within `NUM_REQ-1` other grants.

## Test plan
- **Single requester:** after reset, `req_valid[2] = 1` with data 0x00A0..0x00A5 and no last. Expect grant in cycle 1 and writes 0xA0..0xA3 tagged id 2 in cycles 1–4. Then one IDLE cycle, then writes 0xA4..0xA5. `beat_count` ends at 6.
- **Round robin:** all 4 requesters always valid, `MAX_BURST = 4`. Grant order is 0,1,2,3,0,… with exactly 4 beats each and one bubble between grants. After 40 cycles `beat_count` is 32.
- **req_last:** requester 1 asserts last on its 2nd beat. Release after 2 beats, `rr_ptr` becomes 2, and the next grant goes to requester 2 even though requester 0 is valid.
- **FIFO full:** hold `fifo_wrt_full = 1` for 3 cycles mid-burst. `fifo_wrt_en` and `req_ready` stay 0 for those 3 cycles, `burst_cnt` is frozen, and the burst resumes with no beat lost or duplicated. Also connect a real `async_fifo` with `ADDR_LEN = 4`: after 16 writes with no reads, no further write is issued.
- **Valid drop:** the granted requester deasserts valid mid-burst. Release occurs in that cycle and no write is issued.
- **Reset mid-burst:** assert `reset` for 1 cycle during beat 2. No write in the reset cycle. Afterwards `busy = 0`, `rr_ptr = 0`, `beat_count = 0`, and the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one async FIFO write port among NUM_REQ producers.
// Each written beat carries its source index in the upper ID_LEN bits of the FIFO word.
`timescale 1ns/1ps
module async_fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_LEN  = 16,
  parameter int unsigned ID_LEN    = $clog2(NUM_REQ),
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [ID_LEN+DATA_LEN-1:0]   fifo_data_in,
  output logic                         fifo_wrt_en,
  input  logic                         fifo_wrt_full,
  output logic                         busy,
  output logic [ID_LEN-1:0]            grant_id,
  output logic [31:0]                  beat_count
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST) + 1;
  localparam int unsigned SUM_W   = ID_LEN + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]          state, state_nxt;
  logic [ID_LEN-1:0]   grant_nxt;
  logic [ID_LEN-1:0]   rr_ptr, rr_ptr_nxt;
  logic [BURST_W-1:0]  burst_cnt, burst_cnt_nxt;
  logic [31:0]         beat_count_nxt;

  logic                sel_valid;
  logic                sel_last;
  logic [DATA_LEN-1:0] sel_data;

  logic                any_valid;
  logic [ID_LEN-1:0]   pick_id;

  logic                xfer;
  logic                release_burst;
  logic [ID_LEN-1:0]   grant_inc;

  // Select the granted requester's valid/last/data
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_LEN'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  // Rotate valids so rr_ptr sits at bit 0, take the first set bit, then map back
  always_comb begin
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_LEN-1:0]    off;
    logic [SUM_W-1:0]     sum;
    dbl       = {req_valid, req_valid} >> rr_ptr;
    rot       = dbl[NUM_REQ-1:0];
    off       = '0;
    any_valid = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!any_valid && rot[j]) begin
        any_valid = 1'b1;
        off       = ID_LEN'(j);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= SUM_W'(NUM_REQ)) begin
      sum = sum - SUM_W'(NUM_REQ);
    end
    pick_id = sum[ID_LEN-1:0];
  end

  assign grant_inc = (grant_id == ID_LEN'(NUM_REQ - 1)) ? '0 : grant_id + ID_LEN'(1);

  // Next-state and write-port control
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    rr_ptr_nxt     = rr_ptr;
    burst_cnt_nxt  = burst_cnt;
    beat_count_nxt = beat_count;
    xfer           = 1'b0;
    release_burst  = 1'b0;
    fifo_wrt_en    = 1'b0;
    req_ready      = '0;

    case (state)
      IDLE: begin
        if (any_valid) begin
          grant_nxt     = pick_id;
          burst_cnt_nxt = '0;
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        xfer = sel_valid & ~fifo_wrt_full;
        if (xfer) begin
          burst_cnt_nxt  = burst_cnt + BURST_W'(1);
          beat_count_nxt = beat_count + 32'd1;
        end
        release_burst = (xfer & (sel_last | (burst_cnt == BURST_W'(MAX_BURST - 1)))) | ~sel_valid;
        if (release_burst) begin
          rr_ptr_nxt = grant_inc;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A beat in flight during reset is dropped, never written
    fifo_wrt_en = xfer & ~reset;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = fifo_wrt_en & (grant_id == ID_LEN'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_id   <= '0;
      rr_ptr     <= '0;
      burst_cnt  <= '0;
      beat_count <= '0;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      rr_ptr     <= rr_ptr_nxt;
      burst_cnt  <= burst_cnt_nxt;
      beat_count <= beat_count_nxt;
    end
  end

  assign busy         = (state == BUSY);
  assign fifo_data_in = {grant_id, sel_data};

endmodule
